// File: rtl/dmem_resp_pkg.sv
// Shared encodings for the data-memory responder: RISC-V funct3 access sizes
// and the request-handling FSM states.
package dmem_resp_pkg;

   localparam logic [2:0] DM_SIZE_B  = 3'b000;
   localparam logic [2:0] DM_SIZE_H  = 3'b001;
   localparam logic [2:0] DM_SIZE_W  = 3'b010;
   localparam logic [2:0] DM_SIZE_BU = 3'b100;
   localparam logic [2:0] DM_SIZE_HU = 3'b101;

   typedef enum logic [1:0] {
      DM_IDLE = 2'd0,
      DM_WAIT = 2'd1,
      DM_RESP = 2'd2
   } dm_state_e;

endpackage

// File: rtl/dmem_resp_lane.sv
// Byte-lane datapath for one word: load extraction/extension, store merge and
// per-access legality flags (misalignment, illegal size code).
module dmem_resp_lane
   import dmem_resp_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  off,
   input  logic [2:0]  size,
   input  logic        we,
   output logic [31:0] load_data,
   output logic [31:0] store_word,
   output logic        misaligned,
   output logic        illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = old_word[{off, 3'b000} +: 8];
      half_sel = off[1] ? old_word[31:16] : old_word[15:0];

      load_data = old_word;
      case (size)
         DM_SIZE_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
         DM_SIZE_BU: load_data = {24'h0, byte_sel};
         DM_SIZE_H:  load_data = {{16{half_sel[15]}}, half_sel};
         DM_SIZE_HU: load_data = {16'h0, half_sel};
         default:    load_data = old_word;
      endcase

      // Read-modify-write: untouched lanes keep their old contents.
      store_word = old_word;
      case (size)
         DM_SIZE_B: store_word[{off, 3'b000} +: 8]   = wdata[7:0];
         DM_SIZE_H: store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
         DM_SIZE_W: store_word = wdata;
         default:   store_word = old_word;
      endcase

      misaligned = (((size == DM_SIZE_H) || (size == DM_SIZE_HU)) && off[0])
                || ((size == DM_SIZE_W) && (off != 2'b00));

      illegal = (size == 3'b011) || (size == 3'b110) || (size == 3'b111)
             || (we && ((size == DM_SIZE_BU) || (size == DM_SIZE_HU)));
   end

endmodule

// File: rtl/dmem_resp.sv
// Target end of the CPU data-memory port: one request at a time, programmable
// wait states, then a held response carrying read data and an error flag.
module dmem_resp
   import dmem_resp_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_we,
   input  logic [31:0]                    req_addr,
   input  logic [2:0]                     req_size,
   input  logic [31:0]                    req_wdata,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [31:0]                    rsp_rdata,
   output logic                           rsp_err,
   input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
   output logic [31:0]                    dbg_data
);

   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   dm_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [2:0]       size_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic          accept, commit_en;
   logic          cur_we;
   logic [31:0]   cur_addr, cur_wdata, cur_off;
   logic [2:0]    cur_size;
   logic [AW-1:0] cur_idx;
   logic          out_of_range, misaligned, illegal;
   logic [31:0]   load_data, store_word;

   assign req_ready = rst && (state_q == DM_IDLE);
   assign accept    = req_valid && req_ready;

   // With zero wait states the commit happens on the accept edge, so it has to
   // work from the live request rather than the latched copy.
   assign cur_we    = (state_q == DM_IDLE) ? req_we    : we_q;
   assign cur_addr  = (state_q == DM_IDLE) ? req_addr  : addr_q;
   assign cur_size  = (state_q == DM_IDLE) ? req_size  : size_q;
   assign cur_wdata = (state_q == DM_IDLE) ? req_wdata : wdata_q;

   assign cur_off      = cur_addr - ADDR_BASE;
   assign cur_idx      = cur_off[AW+1:2];
   assign out_of_range = {2'b00, cur_off[31:2]} >= 32'(DEPTH_WORDS);

   assign commit_en = (WAIT_CYCLES == 0) ? accept
                                         : ((state_q == DM_WAIT) && (cnt_q == '0));

   dmem_resp_lane u_lane (
      .old_word   (mem[cur_idx]),
      .wdata      (cur_wdata),
      .off        (cur_off[1:0]),
      .size       (cur_size),
      .we         (cur_we),
      .load_data  (load_data),
      .store_word (store_word),
      .misaligned (misaligned),
      .illegal    (illegal)
   );

   assign err_d   = out_of_range || misaligned || illegal;
   assign rdata_d = (err_d || cur_we) ? 32'h0 : load_data;

   always_ff @(posedge clk) begin
      if (commit_en && cur_we && !err_d) begin
         mem[cur_idx] <= store_word;
      end
   end

   assign dbg_data  = mem[dbg_addr];
   assign rsp_valid = (state_q == DM_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DM_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         size_q  <= 3'b000;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         if (commit_en) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end
         case (state_q)
            DM_IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  size_q  <= req_size;
                  wdata_q <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= DM_RESP;
                  end else begin
                     state_q <= DM_WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            DM_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= DM_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DM_RESP: begin
               if (rsp_ready) begin
                  state_q <= DM_IDLE;
               end
            end
            default: state_q <= DM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three builds (0, 1 and 3 wait states) sharing
// the request bus, each with its own valid and reset.
module tb_dmem_resp;

   logic        clk;
   logic        rst_a       [3];
   logic        req_valid_a [3];
   logic        req_ready_a [3];
   logic        rsp_valid_a [3];
   logic [31:0] rsp_rdata_a [3];
   logic        rsp_err_a   [3];
   logic [31:0] dbg_data_a  [3];

   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_ready;
   logic [9:0]  dbg_addr;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst_a[0]), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
      .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a[0]),
      .rsp_err(rsp_err_a[0]), .dbg_addr(dbg_addr), .dbg_data(dbg_data_a[0]));

   dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst_a[1]), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
      .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a[1]),
      .rsp_err(rsp_err_a[1]), .dbg_addr(dbg_addr), .dbg_data(dbg_data_a[1]));

   dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst_a[2]), .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]),
      .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_a[2]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a[2]),
      .rsp_err(rsp_err_a[2]), .dbg_addr(dbg_addr), .dbg_data(dbg_data_a[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got still running expected finished");
      $fatal(1, "global timeout");
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [31:0] exp_dbg;
   } vec_t;

   vec_t vecs [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic issue(input int d, input logic we, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata);
      int guard;
      guard = 0;
      @(negedge clk);
      req_valid_a[d] = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_size  = size;
      req_wdata = wdata;
      while (!req_ready_a[d] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no req_ready expected req_ready within 50 cycles");
      end
      @(posedge clk);
      #1;
      // Scramble the bus after the accept edge; the responder must use its latched copy.
      req_valid_a[d] = 1'b0;
      req_we    = ~we;
      req_addr  = 32'hFFFF_FFFC;
      req_size  = 3'b111;
      req_wdata = 32'h5A5A_5A5A;
   endtask

   task automatic collect(input int d, output logic [31:0] rdata, output logic err, output int lat);
      lat = 1;
      while (!rsp_valid_a[d] && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rdata = rsp_rdata_a[d];
      err   = rsp_err_a[d];
   endtask

   task automatic release_rsp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rdata;
      logic        err;
      int          lat;

      //             we    addr        size    wdata          rdata          err   dbg word 4
      vecs[0]  = '{1'b1, 32'h10,   3'b010, 32'h8000_00F1, 32'h0000_0000, 1'b0, 32'h8000_00F1};
      vecs[1]  = '{1'b0, 32'h10,   3'b010, 32'h0,         32'h8000_00F1, 1'b0, 32'h8000_00F1};
      vecs[2]  = '{1'b1, 32'h11,   3'b000, 32'hFFFF_FFAB, 32'h0000_0000, 1'b0, 32'h8000_ABF1};
      vecs[3]  = '{1'b0, 32'h11,   3'b000, 32'h0,         32'hFFFF_FFAB, 1'b0, 32'h8000_ABF1};
      vecs[4]  = '{1'b0, 32'h11,   3'b100, 32'h0,         32'h0000_00AB, 1'b0, 32'h8000_ABF1};
      vecs[5]  = '{1'b1, 32'h12,   3'b001, 32'hFFFF_1234, 32'h0000_0000, 1'b0, 32'h1234_ABF1};
      vecs[6]  = '{1'b0, 32'h12,   3'b001, 32'h0,         32'h0000_1234, 1'b0, 32'h1234_ABF1};
      vecs[7]  = '{1'b0, 32'h10,   3'b010, 32'h0,         32'h1234_ABF1, 1'b0, 32'h1234_ABF1};
      vecs[8]  = '{1'b0, 32'h13,   3'b010, 32'h0,         32'h0000_0000, 1'b1, 32'h1234_ABF1};
      vecs[9]  = '{1'b1, 32'h11,   3'b001, 32'h0000_BEEF, 32'h0000_0000, 1'b1, 32'h1234_ABF1};
      vecs[10] = '{1'b0, 32'h10,   3'b010, 32'h0,         32'h1234_ABF1, 1'b0, 32'h1234_ABF1};
      vecs[11] = '{1'b0, 32'h1000, 3'b010, 32'h0,         32'h0000_0000, 1'b1, 32'h1234_ABF1};
      vecs[12] = '{1'b0, 32'h10,   3'b110, 32'h0,         32'h0000_0000, 1'b1, 32'h1234_ABF1};
      vecs[13] = '{1'b1, 32'h10,   3'b100, 32'h0000_0077, 32'h0000_0000, 1'b1, 32'h1234_ABF1};
      vecs[14] = '{1'b1, 32'h12,   3'b001, 32'h0000_8765, 32'h0000_0000, 1'b0, 32'h8765_ABF1};
      vecs[15] = '{1'b0, 32'h12,   3'b001, 32'h0,         32'hFFFF_8765, 1'b0, 32'h8765_ABF1};
      vecs[16] = '{1'b0, 32'h12,   3'b101, 32'h0,         32'h0000_8765, 1'b0, 32'h8765_ABF1};
      vecs[17] = '{1'b0, 32'h10,   3'b000, 32'h0,         32'hFFFF_FFF1, 1'b0, 32'h8765_ABF1};
      vecs[18] = '{1'b0, 32'h13,   3'b100, 32'h0,         32'h0000_0087, 1'b0, 32'h8765_ABF1};
      vecs[19] = '{1'b0, 32'h10,   3'b001, 32'h0,         32'hFFFF_ABF1, 1'b0, 32'h8765_ABF1};

      for (int d = 0; d < 3; d++) begin
         rst_a[d]       = 1'b0;
         req_valid_a[d] = 1'b0;
      end
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_size  = 3'b010;
      req_wdata = 32'h0;
      rsp_ready = 1'b0;
      dbg_addr  = 10'd4;

      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst%0d_req_ready", d), {31'b0, req_ready_a[d]}, 32'd0);
         check($sformatf("rst%0d_rsp_valid", d), {31'b0, rsp_valid_a[d]}, 32'd0);
         check($sformatf("rst%0d_rsp_rdata", d), rsp_rdata_a[d], 32'd0);
         check($sformatf("rst%0d_rsp_err", d), {31'b0, rsp_err_a[d]}, 32'd0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) rst_a[d] = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("post_rst%0d_req_ready", d), {31'b0, req_ready_a[d]}, 32'd1);
      end

      // Table-driven transactions on the one-wait-state build.
      for (int i = 0; i < 20; i++) begin
         issue(1, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata);
         collect(1, rdata, err, lat);
         $display("vec%0d we=%0d addr=0x%08h size=%03b -> rdata=0x%08h err=%0d lat=%0d dbg=0x%08h",
                  i, vecs[i].we, vecs[i].addr, vecs[i].size, rdata, err, lat, dbg_data_a[1]);
         check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         check($sformatf("vec%0d_dbg", i), dbg_data_a[1], vecs[i].exp_dbg);
         release_rsp();
      end

      // Response held while the requester stalls.
      issue(1, 1'b0, 32'h10, 3'b010, 32'h0);
      collect(1, rdata, err, lat);
      check("stall_first_rdata", rdata, 32'h8765_ABF1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall%0d_rsp_valid", i), {31'b0, rsp_valid_a[1]}, 32'd1);
         check($sformatf("stall%0d_rsp_rdata", i), rsp_rdata_a[1], 32'h8765_ABF1);
         check($sformatf("stall%0d_req_ready", i), {31'b0, req_ready_a[1]}, 32'd0);
      end
      release_rsp();
      $display("stall handshake done: req_ready=%0d rsp_valid=%0d", req_ready_a[1], rsp_valid_a[1]);
      check("stall_after_req_ready", {31'b0, req_ready_a[1]}, 32'd1);
      check("stall_after_rsp_valid", {31'b0, rsp_valid_a[1]}, 32'd0);

      // Zero-wait-state build.
      dbg_addr = 10'd16;
      issue(0, 1'b1, 32'h40, 3'b010, 32'hCAFE_F00D);
      collect(0, rdata, err, lat);
      $display("w0 sw 0x40 -> err=%0d lat=%0d", err, lat);
      check("w0_sw_latency", 32'(lat), 32'd1);
      check("w0_sw_err", {31'b0, err}, 32'd0);
      release_rsp();
      issue(0, 1'b0, 32'h40, 3'b010, 32'h0);
      collect(0, rdata, err, lat);
      $display("w0 lw 0x40 -> rdata=0x%08h err=%0d lat=%0d", rdata, err, lat);
      check("w0_lw_latency", 32'(lat), 32'd1);
      check("w0_lw_rdata", rdata, 32'hCAFE_F00D);
      check("w0_dbg", dbg_data_a[0], 32'hCAFE_F00D);
      release_rsp();

      // Three-wait-state build: reset lands in WAIT before the commit edge.
      dbg_addr = 10'd8;
      issue(2, 1'b1, 32'h20, 3'b010, 32'h1111_2222);
      collect(2, rdata, err, lat);
      $display("w3 sw 0x20 -> err=%0d lat=%0d", err, lat);
      check("w3_sw_latency", 32'(lat), 32'd4);
      release_rsp();
      issue(2, 1'b1, 32'h20, 3'b010, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_a[2] = 1'b0;
      #1;
      check("w3_in_rst_req_ready", {31'b0, req_ready_a[2]}, 32'd0);
      check("w3_in_rst_rsp_valid", {31'b0, rsp_valid_a[2]}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_a[2] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("w3_after_rst%0d_rsp_valid", i), {31'b0, rsp_valid_a[2]}, 32'd0);
      end
      $display("w3 reset mid-WAIT -> word 0x20 = 0x%08h", dbg_data_a[2]);
      check("w3_word_unchanged", dbg_data_a[2], 32'h1111_2222);
      check("w3_after_rst_req_ready", {31'b0, req_ready_a[2]}, 32'd1);
      issue(2, 1'b0, 32'h20, 3'b010, 32'h0);
      collect(2, rdata, err, lat);
      $display("w3 lw 0x20 -> rdata=0x%08h err=%0d lat=%0d", rdata, err, lat);
      check("w3_lw_rdata", rdata, 32'h1111_2222);
      check("w3_lw_latency", 32'(lat), 32'd4);
      release_rsp();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder for the CPU's load/store port: the target end of the CPU data-memory interface.
- Accepts one request at a time via a valid/ready handshake and serves it from internal word-organised storage.
- Inserts a programmable number of wait states, then returns a held response with read data and an error flag.
- Handles byte, halfword and word accesses using RISC-V funct3 size encoding, including load sign/zero extension and store byte-lane merging.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit storage words; must be a power of two.
- WAIT_CYCLES, 1: wait-state cycles between accept and data commit; 0 is legal.
- ADDR_BASE, 32'h0000_0000: byte address of word 0; must be word aligned.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  3  funct3 code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_wdata  in  32  store data, LSB-aligned (rs2 value).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester takes response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal size.
- dbg_addr  in  log2(DEPTH_WORDS)  debug word index.
- dbg_data  out  32  combinational read of storage[dbg_addr].

Behaviour:
- States: IDLE, WAIT, RESP.
- rst low (async): state = IDLE; req_ready = 0 while rst is low; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0. Storage contents are not reset.
- After rst deasserts, req_ready = 1 exactly when state = IDLE.
- Accept: req_valid && req_ready at a rising edge. The block latches we, addr, size and wdata at that edge.
- Transition from IDLE on accept:
  - WAIT_CYCLES = 0: go to RESP. Commit happens at that same edge.
  - WAIT_CYCLES > 0: go to WAIT with counter = WAIT_CYCLES - 1.
- In WAIT: the counter decrements each cycle. When the counter is 0, the next edge goes to RESP and commits.
- Commit edge actions:
  - Evaluate the error checks below.
  - Store without error: write the merged word into storage.
  - Load without error: register the extended read into rsp_rdata.
  - Error: no storage change; rsp_rdata = 0; rsp_err = 1.
  - Non-error store: rsp_rdata = 0; rsp_err = 0.
- Latency: rsp_valid rises WAIT_CYCLES + 1 cycles after the accept edge.
- In RESP: rsp_valid = 1, with rsp_rdata and rsp_err held stable. On rsp_valid && rsp_ready the next state is IDLE and rsp_valid drops. A new request is not accepted in the same cycle, so the minimum issue interval is WAIT_CYCLES + 2 cycles.
- Error checks (evaluated on the latched request):
  - off = addr - ADDR_BASE. Out of range if off[31:2] >= DEPTH_WORDS; this includes addr < ADDR_BASE through unsigned wrap.
  - Misaligned: h/hu with off[0] = 1; w with off[1:0] != 0.
  - Illegal size: codes 011, 110, 111 for any access; 100 and 101 for stores.
- Load extraction: select byte off[1:0] or halfword off[1]. b/h sign-extend; bu/hu zero-extend; w passes through.
- Store merge:
  - b: replace byte lane off[1:0] with wdata[7:0].
  - h: replace half lane off[1] with wdata[15:0].
  - w: replace the whole word.
  - Other lanes are preserved (read-modify-write inside the commit edge).
- dbg_data reflects a commit on the cycle after the commit edge.
- Reset mid-transaction: the request is abandoned. If the commit edge has not occurred, storage is unchanged. No response is issued.
- Inputs are ignored outside IDLE, and req_* may change freely after the accept edge.

Decomposition:
- Shared include file dmem_def.v, alongside the existing ctrl encode definitions, holds:
  - size codes DM_SIZE_B/H/W/BU/HU;
  - state encodings DM_IDLE/DM_WAIT/DM_RESP.
- Sub-module dmem_lane (combinational): inputs old word, wdata, off[1:0], size. Outputs load-extended data, merged store word and misaligned/illegal flags. It is reused by the top's commit logic.

Test Plan:
- WAIT_CYCLES=1: sw 0x8000_00F1 to 0x10, then lw 0x10. The lw has rsp_valid 2 cycles after accept, rsp_rdata = 0x8000_00F1, rsp_err = 0.
- sb 0xAB to 0x11, then lb 0x11 and lbu 0x11. Results are 0xFFFF_FFAB and 0x0000_00AB; the word at 0x10 reads 0x8000_ABF1 via dbg_addr = 4.
- sh 0x1234 to 0x12, then lh 0x12 and lw 0x10. Results are 0x0000_1234 and 0x1234_ABF1.
- Error cases:
  - lw at 0x13: rsp_err = 1, rsp_rdata = 0.
  - sh at 0x11: rsp_err = 1, storage unchanged.
  - Address DEPTH_WORDS*4: rsp_err = 1.
  - size 110: rsp_err = 1.
- rsp_ready held low 5 cycles in RESP: rsp_valid/rsp_rdata stable and req_ready = 0 throughout; after the handshake, req_ready = 1 next cycle.
- Reset mid-transaction (WAIT_CYCLES=3): rst low in WAIT during an sw to 0x20. rsp_valid stays 0 and the word at 0x20 is unchanged.
- WAIT_CYCLES=0 build: rsp_valid 1 cycle after accept.
